// File: rtl/rr_sched_pkg.sv
// rtl/rr_sched_pkg.sv - shared state encoding and sizing helper for the round-robin memory scheduler
package rr_sched_pkg;

  typedef enum logic [1:0] {IDLE, REQ, HOLD, DROP} sched_state_t;

  // Index width with a floor of one bit so a single-requester build still has a sel port.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin finder: first set request at or above ptr, wrapping to 0
module rr_pick
  import rr_sched_pkg::*;
#(
  parameter int N_REQ = 8,
  parameter int SEL_W = clog2_min1(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             valid,
  output logic [SEL_W-1:0] idx
);

  logic             hi_hit;
  logic [SEL_W-1:0] hi_idx;
  logic             lo_hit;
  logic [SEL_W-1:0] lo_idx;

  // Descending scan so the last hit written is the lowest index; the upper pass wins over the wrap pass.
  always_comb begin
    hi_hit = 1'b0;
    hi_idx = '0;
    lo_hit = 1'b0;
    lo_idx = '0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (req[j]) begin
        lo_hit = 1'b1;
        lo_idx = SEL_W'(j);
        if (SEL_W'(j) >= ptr) begin
          hi_hit = 1'b1;
          hi_idx = SEL_W'(j);
        end
      end
    end
  end

  assign valid = lo_hit;
  assign idx   = hi_hit ? hi_idx : lo_idx;

endmodule

// File: rtl/rr_mem_scheduler.sv
// rtl/rr_mem_scheduler.sv - shares one 4-phase memory port among N_REQ 4-phase requesters, round-robin
// Optional RR_SCHED_SYNC_EN adds 2-flop synchronizers on req_in and ack_out.
module rr_mem_scheduler
  import rr_sched_pkg::*;
#(
  parameter  int N_REQ = 8,
  localparam int SEL_W = clog2_min1(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_in,
  output logic [N_REQ-1:0] ack_in,
  output logic             req_out,
  input  logic             ack_out,
  output logic [SEL_W-1:0] sel,
  output logic             busy
);

  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_REQ - 1);

  logic [N_REQ-1:0] req_s;
  logic             ack_s;

`ifdef RR_SCHED_SYNC_EN
  logic [N_REQ-1:0] req_m_q, req_s_q;
  logic             ack_m_q, ack_s_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      req_m_q <= '0;
      req_s_q <= '0;
      ack_m_q <= 1'b0;
      ack_s_q <= 1'b0;
    end else begin
      req_m_q <= req_in;
      req_s_q <= req_m_q;
      ack_m_q <= ack_out;
      ack_s_q <= ack_m_q;
    end
  end

  assign req_s = req_s_q;
  assign ack_s = ack_s_q;
`else
  assign req_s = req_in;
  assign ack_s = ack_out;
`endif

  sched_state_t     state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic             req_out_q, req_out_d;
  logic [N_REQ-1:0] ack_in_q, ack_in_d;
  logic             busy_q, busy_d;

  logic             pick_valid;
  logic [SEL_W-1:0] pick_idx;

  rr_pick #(
    .N_REQ (N_REQ),
    .SEL_W (SEL_W)
  ) u_pick (
    .req   (req_s),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    req_out_d = req_out_q;
    ack_in_d  = ack_in_q;
    unique case (state_q)
      IDLE: begin
        ack_in_d = '0;
        if (pick_valid) begin
          sel_d     = pick_idx;
          req_out_d = 1'b1;
          state_d   = REQ;
        end
      end
      // A winner withdrawing here is deliberately not looked at; HOLD catches it once memory acks.
      REQ: begin
        if (ack_s) begin
          ack_in_d = N_REQ'(1) << sel_q;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (!req_s[sel_q]) begin
          req_out_d = 1'b0;
          state_d   = DROP;
        end
      end
      DROP: begin
        if (!ack_s) begin
          ack_in_d = '0;
          ptr_d    = (sel_q == SEL_LAST) ? '0 : sel_q + SEL_W'(1);
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      ptr_q     <= '0;
      req_out_q <= 1'b0;
      ack_in_q  <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      req_out_q <= req_out_d;
      ack_in_q  <= ack_in_d;
      busy_q    <= busy_d;
    end
  end

  assign ack_in  = ack_in_q;
  assign req_out = req_out_q;
  assign sel     = sel_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_rr_mem_scheduler.sv
// tb/tb_rr_mem_scheduler.sv - directed checks of rr_mem_scheduler with N_REQ=8 and N_REQ=5 instances
module tb_rr_mem_scheduler;

`ifdef RR_SCHED_SYNC_EN
  localparam int L = 2;
`else
  localparam int L = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req8 = '0;
  logic [7:0] ack_in8;
  logic       req_out8;
  logic       ack8 = 1'b0;
  logic [2:0] sel8;
  logic       busy8;
  logic [4:0] req5 = '0;
  logic [4:0] ack_in5;
  logic       req_out5;
  logic       ack5 = 1'b0;
  logic [2:0] sel5;
  logic       busy5;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rr_mem_scheduler #(.N_REQ(8)) u8 (
    .clk(clk), .rst(rst), .req_in(req8), .ack_in(ack_in8),
    .req_out(req_out8), .ack_out(ack8), .sel(sel8), .busy(busy8)
  );

  rr_mem_scheduler #(.N_REQ(5)) u5 (
    .clk(clk), .rst(rst), .req_in(req5), .ack_in(ack_in5),
    .req_out(req_out5), .ack_out(ack5), .sel(sel5), .busy(busy5)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete 4-phase transaction; the requester withdraws all bits when it sees its grant held.
  task automatic txn(input bit five, input logic [7:0] vec, input int exp_sel, input string tag);
    logic [31:0] onehot;
    onehot = 32'(1) << exp_sel;
    if (five) req5 = vec[4:0]; else req8 = vec;
    tick(L + 1);
    chk({tag, ".req_out1"}, five ? req_out5 : req_out8, 1);
    chk({tag, ".sel"}, five ? sel5 : sel8, exp_sel);
    chk({tag, ".busy1"}, five ? busy5 : busy8, 1);
    if (five) ack5 = 1'b1; else ack8 = 1'b1;
    tick(L + 1);
    chk({tag, ".ack_in"}, five ? {3'b0, ack_in5} : ack_in8, onehot);
    if (five) req5 = '0; else req8 = '0;
    tick(L + 1);
    chk({tag, ".req_out0"}, five ? req_out5 : req_out8, 0);
    chk({tag, ".ack_hold"}, five ? {3'b0, ack_in5} : ack_in8, onehot);
    if (five) ack5 = 1'b0; else ack8 = 1'b0;
    tick(L + 1);
    chk({tag, ".ack_in0"}, five ? {3'b0, ack_in5} : ack_in8, 0);
    chk({tag, ".busy0"}, five ? busy5 : busy8, 0);
  endtask

  initial begin
    tick(3);
    rst = 1'b0;
    chk("reset.ack_in", ack_in8, 0);
    chk("reset.req_out", req_out8, 0);
    chk("reset.sel", sel8, 0);
    chk("reset.busy", busy8, 0);
    chk("reset5.busy", busy5, 0);

    // single request, then ptr=3 shown by 2 losing to 3
    txn(1'b0, 8'h04, 2, "t1");
    txn(1'b0, 8'h0D, 3, "t1.ptr");

    // round-robin sweep from a fresh pointer
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    for (int i = 0; i < 9; i++) txn(1'b0, 8'hFF, i % 8, $sformatf("t2.%0d", i));

    // N_REQ=5: ptr moved to 4, then wrap skips to 0, then 1
    txn(1'b1, 8'h08, 3, "t3.a");
    txn(1'b1, 8'h03, 0, "t3.b");
    txn(1'b1, 8'h03, 1, "t3.c");

    // winner 3 withdraws before memory acks (ptr is 1 after the sweep)
    req8 = 8'h08;
    tick(L + 1);
    chk("t4.sel", sel8, 3);
    req8 = 8'h00;
    tick(L + 2);
    chk("t4.req_wait", req_out8, 1);
    chk("t4.no_ack", ack_in8, 0);
    ack8 = 1'b1;
    tick(L + 1);
    chk("t4.hold_ack", ack_in8, 8'h08);
    chk("t4.hold_req", req_out8, 1);
    tick(1);
    chk("t4.drop_req", req_out8, 0);
    chk("t4.drop_ack", ack_in8, 8'h08);
    ack8 = 1'b0;
    tick(L + 1);
    chk("t4.idle_ack", ack_in8, 0);
    chk("t4.idle_busy", busy8, 0);

    // reset while holding requester 5 (ptr is 4 here)
    req8 = 8'h20;
    tick(L + 1);
    chk("t5.sel", sel8, 5);
    ack8 = 1'b1;
    tick(L + 1);
    chk("t5.hold", ack_in8, 8'h20);
    rst = 1'b1;
    tick(1);
    chk("t5.rst_ack", ack_in8, 0);
    chk("t5.rst_req", req_out8, 0);
    chk("t5.rst_sel", sel8, 0);
    chk("t5.rst_busy", busy8, 0);
    rst = 1'b0;
    ack8 = 1'b0;
    req8 = 8'h00;
    tick(2);
    txn(1'b0, 8'h21, 0, "t5.ptr0");
    txn(1'b0, 8'h80, 7, "t5.b7");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
